pll_lock_seq: RTL

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_seq.sv
// ============================================================================
// Module      : pll_lock_seq
// Description : PLL power-up/lock sequencer with lock qualification, retry,
//               dynamic ODIV0 reconfiguration and downstream reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_seq #(
    parameter int PWD_CYCLES   = 64,
    parameter int RST_CYCLES   = 256,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int ODIV_DEFAULT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [6:0] cfg_odiv,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       pll_pwd,
    output logic       pll_reset,
    output logic [6:0] pll_odsel0,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam logic [2:0] S_PWD       = 3'd0;
    localparam logic [2:0] S_RST       = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    // Terminal counts: a state is left on the edge where the counter holds N-1.
    localparam logic [19:0] c_pwd_last  = 20'(PWD_CYCLES - 1);
    localparam logic [19:0] c_rst_last  = 20'(RST_CYCLES - 1);
    localparam logic [19:0] c_tmo_last  = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] c_stb_last  = 20'(LOCK_STABLE - 1);
    localparam logic [1:0]  c_max_retry = 2'(MAX_RETRY);
    localparam logic [6:0]  c_odiv_dflt = 7'(ODIV_DEFAULT);

    logic [2:0]  r_state;
    logic [19:0] r_cnt;
    logic        r_lock_meta;
    logic        r_lock_s;
    logic        r_cfg_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PWD;
            r_cnt      <= 20'd0;
            r_cfg_pend <= 1'b0;
            pll_pwd    <= 1'b1;
            pll_reset  <= 1'b1;
            pll_odsel0 <= c_odiv_dflt;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            cfg_ack    <= 1'b0;
            cfg_err    <= 1'b0;
            retry_cnt  <= 2'd0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            case (r_state)
                S_PWD: begin
                    if (r_cnt == c_pwd_last) begin
                        r_state   <= S_RST;
                        r_cnt     <= 20'd0;
                        pll_pwd   <= 1'b0;
                        pll_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end

                S_RST: begin
                    if (r_cnt == c_rst_last) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= 20'd0;
                        pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= 20'd0;
                    end else if (r_cnt == c_tmo_last) begin
                        r_cnt <= 20'd0;
                        if (retry_cnt == c_max_retry) begin
                            r_state   <= S_FAIL;
                            pll_pwd   <= 1'b1;
                            pll_reset <= 1'b1;
                            fail      <= 1'b1;
                            // An accepted reconfiguration can never complete now.
                            if (r_cfg_pend) begin
                                cfg_ack    <= 1'b1;
                                cfg_err    <= 1'b1;
                                r_cfg_pend <= 1'b0;
                            end
                        end else begin
                            r_state   <= S_RST;
                            retry_cnt <= retry_cnt + 2'd1;
                            pll_reset <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end

                S_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= 20'd0;
                    end else if (r_cnt == c_stb_last) begin
                        r_state   <= S_RUN;
                        r_cnt     <= 20'd0;
                        locked    <= 1'b1;
                        sys_rst_n <= 1'b1;
                        retry_cnt <= 2'd0;
                        if (r_cfg_pend) begin
                            cfg_ack    <= 1'b1;
                            r_cfg_pend <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end

                S_RUN: begin
                    r_cnt <= 20'd0;
                    if (!r_lock_s) begin
                        r_state   <= S_RST;
                        locked    <= 1'b0;
                        sys_rst_n <= 1'b0;
                        pll_reset <= 1'b1;
                    // While cfg_ack is high the requester has not yet dropped
                    // cfg_req, so that cycle is not a fresh request.
                    end else if (cfg_req && !cfg_ack) begin
                        if (cfg_odiv != 7'd0) begin
                            r_state    <= S_RST;
                            pll_odsel0 <= cfg_odiv;
                            r_cfg_pend <= 1'b1;
                            locked     <= 1'b0;
                            sys_rst_n  <= 1'b0;
                            pll_reset  <= 1'b1;
                        end else begin
                            cfg_ack <= 1'b1;
                            cfg_err <= 1'b1;
                        end
                    end
                end

                S_FAIL: begin
                    r_cnt <= 20'd0;
                end

                default: begin
                    r_state   <= S_PWD;
                    r_cnt     <= 20'd0;
                    pll_pwd   <= 1'b1;
                    pll_reset <= 1'b1;
                    sys_rst_n <= 1'b0;
                    locked    <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
